fft16_r4_frame_loader: RTL and testbench



---
 rtl/fft_pkg.sv | 14 +
 rtl/fft16_frame_bank.sv | 42 ++++
 rtl/fft16_r4_frame_loader.sv | 134 +++++++++++++
 tb/tb_fft16_r4_frame_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and lane helpers for the 16-point radix-4 FFT path.
// Used by the frame loader and the butterfly stage alike.
package fft_pkg;

   localparam int FFT_N     = 16;
   localparam int FFT_RADIX = 4;
   localparam int FFT_LANES = FFT_N / FFT_RADIX;
   localparam int FFT_IDX_W = $clog2(FFT_N);

   function automatic int lane_lsb(input int width, input int lane);
      return width * lane;
   endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex register bank with a single write port and a
// read port packed as four radix-4 groups of four lanes each.
module fft16_frame_bank
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_rst_n_i,
   input  logic                  wr_en,
   input  logic [FFT_IDX_W-1:0]  wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_real,
   input  logic [DATA_WIDTH-1:0] wr_imag,
   output logic [FFT_LANES-1:0][FFT_RADIX*DATA_WIDTH-1:0] rd_real,
   output logic [FFT_LANES-1:0][FFT_RADIX*DATA_WIDTH-1:0] rd_imag
);

   logic [DATA_WIDTH-1:0] re_q [FFT_N];
   logic [DATA_WIDTH-1:0] im_q [FFT_N];

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         for (int i = 0; i < FFT_N; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else if (wr_en) begin
         re_q[wr_idx] <= wr_real;
         im_q[wr_idx] <= wr_imag;
      end
   end

   // Group g carries x[4g .. 4g+3]; lane l of a group is x[4g+l].
   for (genvar g = 0; g < FFT_LANES; g++) begin : g_grp
      for (genvar l = 0; l < FFT_RADIX; l++) begin : g_lane
         localparam int LSB = lane_lsb(DATA_WIDTH, l);
         assign rd_real[g][LSB +: DATA_WIDTH] = re_q[g*FFT_RADIX+l];
         assign rd_imag[g][LSB +: DATA_WIDTH] = im_q[g*FFT_RADIX+l];
      end
   end

endmodule

// File: rtl/fft16_r4_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the radix-4
// butterfly: 16 streamed complex samples become one packed beat.
module fft16_r4_frame_loader
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_n_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [DATA_WIDTH-1:0]   s_real_i,
   input  logic [DATA_WIDTH-1:0]   s_imag_i,
   input  logic                    s_last_i,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [DATA_WIDTH*4-1:0] xn1_real_o,
   output logic [DATA_WIDTH*4-1:0] xn1_imag_o,
   output logic [DATA_WIDTH*4-1:0] xn2_real_o,
   output logic [DATA_WIDTH*4-1:0] xn2_imag_o,
   output logic [DATA_WIDTH*4-1:0] xn3_real_o,
   output logic [DATA_WIDTH*4-1:0] xn3_imag_o,
   output logic [DATA_WIDTH*4-1:0] xn4_real_o,
   output logic [DATA_WIDTH*4-1:0] xn4_imag_o,
   output logic                    frame_err_o
);

   localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(FFT_N - 1);

   typedef logic [FFT_LANES-1:0][FFT_RADIX*DATA_WIDTH-1:0] grp_t;

   logic [1:0]           full_q, full_d;
   logic                 wr_bank_q, wr_bank_d;
   logic                 rd_bank_q, rd_bank_d;
   logic [FFT_IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic                 err_q, err_d;

   logic accept;
   logic consume;
   logic idx_end;
   logic early_last;

   logic [1:0] bank_we;
   grp_t       bank_re [2];
   grp_t       bank_im [2];
   grp_t       sel_re;
   grp_t       sel_im;

   assign s_ready_o  = !full_q[wr_bank_q];
   assign m_valid_o  = full_q[rd_bank_q];
   assign accept     = s_valid_i && s_ready_o;
   assign consume    = m_valid_o && m_ready_i;
   assign idx_end    = (wr_idx_q == LAST_IDX);
   assign early_last = s_last_i && !idx_end;

   assign bank_we[0] = accept && !wr_bank_q;
   assign bank_we[1] = accept && wr_bank_q;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft16_frame_bank #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .sys_clk_i   (sys_clk_i),
         .sys_rst_n_i (sys_rst_n_i),
         .wr_en       (bank_we[b]),
         .wr_idx      (wr_idx_q),
         .wr_real     (s_real_i),
         .wr_imag     (s_imag_i),
         .rd_real     (bank_re[b]),
         .rd_imag     (bank_im[b])
      );
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
         err_q     <= err_d;
      end
   end

   // Completion and consumption always hit different banks, so both
   // updates to full_d can land in the same cycle.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      err_d     = 1'b0;
      if (consume) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (accept) begin
         unique case (1'b1)
            idx_end: begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = !wr_bank_q;
               wr_idx_d          = '0;
               err_d             = !s_last_i;
            end
            early_last: begin
               wr_idx_d = '0;
               err_d    = 1'b1;
            end
            default: begin
               wr_idx_d = wr_idx_q + 1'b1;
            end
         endcase
      end
   end

   assign sel_re = bank_re[rd_bank_q];
   assign sel_im = bank_im[rd_bank_q];

   assign xn1_real_o  = sel_re[0];
   assign xn2_real_o  = sel_re[1];
   assign xn3_real_o  = sel_re[2];
   assign xn4_real_o  = sel_re[3];
   assign xn1_imag_o  = sel_im[0];
   assign xn2_imag_o  = sel_im[1];
   assign xn3_imag_o  = sel_im[2];
   assign xn4_imag_o  = sel_im[3];
   assign frame_err_o = err_q;

endmodule

// File: tb/tb_fft16_r4_frame_loader.sv
// Directed and throttled-random checks of the ping-pong frame loader.
module tb_fft16_r4_frame_loader;

   logic         sys_clk_i = 1'b0;
   logic         sys_rst_n_i = 1'b0;
   logic         s_valid_i = 1'b0;
   logic         s_ready_o;
   logic [31:0]  s_real_i = '0;
   logic [31:0]  s_imag_i = '0;
   logic         s_last_i = 1'b0;
   logic         m_valid_o;
   logic         m_ready_i = 1'b0;
   logic [127:0] xn1_real_o, xn1_imag_o;
   logic [127:0] xn2_real_o, xn2_imag_o;
   logic [127:0] xn3_real_o, xn3_imag_o;
   logic [127:0] xn4_real_o, xn4_imag_o;
   logic         frame_err_o;

   int checks = 0;
   int errors = 0;

   fft16_r4_frame_loader #(.DATA_WIDTH(32)) dut (
      .sys_clk_i   (sys_clk_i),
      .sys_rst_n_i (sys_rst_n_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .s_real_i    (s_real_i),
      .s_imag_i    (s_imag_i),
      .s_last_i    (s_last_i),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .xn1_real_o  (xn1_real_o),
      .xn1_imag_o  (xn1_imag_o),
      .xn2_real_o  (xn2_real_o),
      .xn2_imag_o  (xn2_imag_o),
      .xn3_real_o  (xn3_real_o),
      .xn3_imag_o  (xn3_imag_o),
      .xn4_real_o  (xn4_real_o),
      .xn4_imag_o  (xn4_imag_o),
      .frame_err_o (frame_err_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] frame_word(input int base, input bit neg);
      logic [511:0] w;
      w = '0;
      for (int i = 0; i < 16; i++)
         w[32*i +: 32] = neg ? 32'(-(base + i)) : 32'(base + i);
      return w;
   endfunction

   function automatic logic [511:0] obs_re();
      return {xn4_real_o, xn3_real_o, xn2_real_o, xn1_real_o};
   endfunction

   function automatic logic [511:0] obs_im();
      return {xn4_imag_o, xn3_imag_o, xn2_imag_o, xn1_imag_o};
   endfunction

   // Presents one sample until accepted, returns #1 after the accepting edge.
   task automatic send(input logic [31:0] re, input logic [31:0] im,
                       input logic last);
      int  n;
      bit  rdy;
      n = 0;
      s_valid_i = 1'b1;
      s_real_i  = re;
      s_imag_i  = im;
      s_last_i  = last;
      do begin
         @(negedge sys_clk_i);
         rdy = s_ready_o;
         @(posedge sys_clk_i);
         #1;
         n++;
      end while (!rdy && n < 200);
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      if (!rdy) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed ready 0 expected 1");
      end
   endtask

   task automatic tick();
      @(posedge sys_clk_i);
      #1;
   endtask

   logic [31:0]  q_re[$];
   logic [31:0]  q_im[$];
   logic [511:0] exp_re, exp_im;
   int           sent, rx, cyc;
   bit           acc, err_seen;

   initial begin
      // reset state
      #12 sys_rst_n_i = 1'b1;
      tick();
      chk("rst_m_valid", m_valid_o, 1'b0);
      chk("rst_s_ready", s_ready_o, 1'b1);
      chk("rst_err", frame_err_o, 1'b0);
      chk("rst_xn", obs_re() | obs_im(), '0);

      // basic frame real=n imag=-n, downstream always ready
      m_ready_i = 1'b1;
      for (int n = 0; n < 16; n++)
         send(32'(n), 32'(-n), n == 15);
      chk("t1_m_valid", m_valid_o, 1'b1);
      chk("t1_xn1_real", xn1_real_o, {32'd3, 32'd2, 32'd1, 32'd0});
      chk("t1_xn3_real", xn3_real_o, {32'd11, 32'd10, 32'd9, 32'd8});
      chk("t1_xn4_imag3", xn4_imag_o[127:96], 32'hFFFF_FFF1);
      chk("t1_frame_im", obs_im(), frame_word(0, 1'b1));
      tick();
      chk("t1_consumed", m_valid_o, 1'b0);

      // three frames against a stalled consumer
      m_ready_i = 1'b0;
      for (int n = 0; n < 32; n++)
         send(32'(100 + n), 32'(-(100 + n)), n % 16 == 15);
      chk("t2_ready_low", s_ready_o, 1'b0);
      s_valid_i = 1'b1;
      s_real_i  = 32'd132;
      s_imag_i  = 32'(-132);
      repeat (3) tick();
      chk("t2_ready_hold", s_ready_o, 1'b0);
      chk("t2_f0_re", obs_re(), frame_word(100, 1'b0));
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("t2_ready_back", s_ready_o, 1'b1);
      chk("t2_f1_valid", m_valid_o, 1'b1);
      chk("t2_f1_x0", xn1_real_o[31:0], 32'd116);
      for (int n = 32; n < 48; n++)
         send(32'(100 + n), 32'(-(100 + n)), n % 16 == 15);
      chk("t2_full_again", s_ready_o, 1'b0);
      chk("t2_f1_stable", obs_re(), frame_word(116, 1'b0));
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("t2_f2_re", obs_re(), frame_word(132, 1'b0));
      chk("t2_f2_xn2_imag", xn2_imag_o,
          {-32'sd139, -32'sd138, -32'sd137, -32'sd136});
      chk("t2_f2_xn4_real3", xn4_real_o[127:96], 32'd147);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("t2_drained", m_valid_o, 1'b0);

      // early last on sample 9 discards the partial frame
      for (int k = 0; k < 10; k++)
         send(32'(200 + k), 32'(k), k == 9);
      chk("t3_err_pulse", frame_err_o, 1'b1);
      chk("t3_no_valid", m_valid_o, 1'b0);
      tick();
      chk("t3_err_once", frame_err_o, 1'b0);
      for (int k = 10; k < 26; k++)
         send(32'(200 + k), 32'(k), k == 25);
      chk("t3_valid", m_valid_o, 1'b1);
      chk("t3_err_clear", frame_err_o, 1'b0);
      chk("t3_frame_re", obs_re(), frame_word(210, 1'b0));
      chk("t3_frame_im", obs_im(), frame_word(10, 1'b0));
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;

      // missing last on sample 15 still completes the frame
      for (int n = 0; n < 16; n++)
         send(32'(300 + n), 32'(-(300 + n)), 1'b0);
      chk("t4_err_pulse", frame_err_o, 1'b1);
      chk("t4_valid", m_valid_o, 1'b1);
      chk("t4_xn2_real", xn2_real_o, {32'd307, 32'd306, 32'd305, 32'd304});
      chk("t4_frame_im", obs_im(), frame_word(300, 1'b1));
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("t4_err_once", frame_err_o, 1'b0);

      // reset mid-frame with one bank full
      for (int n = 0; n < 21; n++)
         send(32'(400 + n), 32'(400 + n), n == 15);
      chk("t5_pre_valid", m_valid_o, 1'b1);
      sys_rst_n_i = 1'b0;
      #1;
      chk("t5_rst_valid", m_valid_o, 1'b0);
      chk("t5_rst_ready", s_ready_o, 1'b1);
      chk("t5_rst_xn", obs_re() | obs_im(), '0);
      @(negedge sys_clk_i);
      sys_rst_n_i = 1'b1;
      tick();
      for (int n = 0; n < 16; n++)
         send(32'(500 + n), 32'(-(500 + n)), n == 15);
      chk("t5_valid", m_valid_o, 1'b1);
      chk("t5_frame_re", obs_re(), frame_word(500, 1'b0));
      chk("t5_frame_im", obs_im(), frame_word(500, 1'b1));
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;

      // throttled random traffic against a queue scoreboard
      sent = 0;
      rx = 0;
      cyc = 0;
      acc = 1'b0;
      err_seen = 1'b0;
      while (rx < 1000 && cyc < 80000) begin
         @(posedge sys_clk_i);
         #1;
         cyc++;
         if (!s_valid_i || acc) begin
            if (sent < 16000 && $urandom_range(3) != 0) begin
               s_valid_i = 1'b1;
               s_real_i  = $urandom;
               s_imag_i  = $urandom;
               s_last_i  = (sent % 16) == 15;
            end else begin
               s_valid_i = 1'b0;
               s_last_i  = 1'b0;
            end
         end
         m_ready_i = $urandom_range(3) != 0;
         @(negedge sys_clk_i);
         acc = s_valid_i && s_ready_o;
         if (acc) begin
            q_re.push_back(s_real_i);
            q_im.push_back(s_imag_i);
            sent++;
         end
         if (frame_err_o) err_seen = 1'b1;
         if (m_valid_o && m_ready_i) begin
            exp_re = 'x;
            exp_im = 'x;
            for (int i = 0; i < 16; i++) begin
               if (q_re.size() > 0) begin
                  exp_re[32*i +: 32] = q_re.pop_front();
                  exp_im[32*i +: 32] = q_im.pop_front();
               end
            end
            chk("rnd_re", obs_re(), exp_re);
            chk("rnd_im", obs_im(), exp_im);
            rx++;
         end
      end
      s_valid_i = 1'b0;
      m_ready_i = 1'b0;
      chk("rnd_frames", 32'(rx), 32'd1000);
      chk("rnd_no_err", err_seen, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
